fetch_arbiter: RTL
==================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter NUM_CONSUMERS, default 2: number of fetchers sharing one program-memory port; must be at least 1.
REQ-002 Parameter ADDR_BITS, default 8: program-memory address width.
REQ-003 Parameter DATA_BITS, default 16: program-memory data (instruction) width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 consumer_read_valid  input  NUM_CONSUMERS  per-fetcher read request, held high until served.
REQ-008 consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  per-fetcher address; consumer i occupies bits [i*ADDR_BITS +: ADDR_BITS].
REQ-009 consumer_read_ready  output  NUM_CONSUMERS  per-fetcher response strobe.
REQ-010 consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  per-fetcher returned instruction; same slicing as the address bus.
REQ-011 mem_read_valid  output  1  request to program memory.
REQ-012 mem_read_address  output  ADDR_BITS  address to program memory.
REQ-013 mem_read_ready  input  1  program memory has data on mem_read_data.
REQ-014 mem_read_data  input  DATA_BITS  program-memory read data.

Function
REQ-015 Three-state FSM: IDLE, READ_WAITING, RELAYING; exactly one consumer is granted at a time; grant index is registered.
REQ-016 IDLE: if any consumer_read_valid is high, grant the first asserted index searching upward from rr_ptr with wrap-around; set mem_read_valid to 1 and mem_read_address to that consumer's address; go to READ_WAITING.
REQ-017 IDLE with no valid requests: hold all outputs; remain in IDLE.
REQ-018 IDLE: ignore mem_read_ready.
REQ-019 READ_WAITING: hold mem_read_valid and mem_read_address stable until mem_read_ready is 1.
REQ-020 READ_WAITING with mem_read_ready: clear mem_read_valid; write mem_read_data into the granted consumer's consumer_read_data slice; set its consumer_read_ready to 1; go to RELAYING.
REQ-021 RELAYING: hold consumer_read_ready high while the granted consumer_read_valid is 1.
REQ-022 RELAYING with granted consumer_read_valid at 0: clear consumer_read_ready; set rr_ptr to (grant+1) mod NUM_CONSUMERS; go to IDLE.
REQ-023 Latency: a request first seen high on edge t drives mem_read_valid from t+1, if IDLE; mem_read_ready seen on edge m drives consumer_read_ready from m+1.
REQ-024 consumer_read_data slices hold their last value until that consumer is served again; slices of other consumers are never modified.
REQ-025 At most one consumer_read_ready bit is high at any time; consumer_read_ready is never high while mem_read_valid is high.
REQ-026 A request that drops during READ_WAITING, which is a protocol violation, still completes the memory transaction; the ready pulse then lasts exactly one cycle.
REQ-027 A consumer that re-asserts valid in the cycle after release competes normally; round-robin prevents starvation: every asserted request is granted within NUM_CONSUMERS transactions.
REQ-028 The minimum back-to-back service period is 4 cycles when the memory answers in one cycle.

Reset
REQ-029 On reset, regardless of state: FSM goes to IDLE; rr_ptr, grant, mem_read_valid, mem_read_address, all consumer_read_ready bits and all consumer_read_data slices go to 0.
REQ-030 Reset asserted mid-transaction abandons the transaction; no ready is issued for it afterwards.

Verification
REQ-031 Single request: consumer 0 valid with address 0x05, memory returns 0x1234 one cycle after mem_read_valid -> mem_read_address=0x05; consumer_read_ready[0] high; data slice 0 = 0x1234; ready drops in the cycle after valid drops.
REQ-032 Contention: both consumers valid from reset, addresses 0x10 and 0x20 -> consumer 0 is served first, then consumer 1; next simultaneous request is served consumer 1 first? No: rr_ptr=0 after serving 1 -> consumer 0 first.
REQ-033 Memory stall: mem_read_ready withheld for 5 cycles -> mem_read_valid and mem_read_address stay stable for all 5 cycles; no consumer_read_ready is asserted.
REQ-034 Reset mid-READ_WAITING: all outputs are 0 on the next edge; a late mem_read_ready produces no consumer_read_ready.
REQ-035 Isolation: serve consumer 1 with 0xBEEF, then consumer 0 with 0x0001 -> slice 1 still reads 0xBEEF.
REQ-036 Early drop: consumer 0 drops valid during READ_WAITING -> after the response, consumer_read_ready[0] is high for exactly one cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/fetch_arbiter.sv
// fetch_arbiter
// Shares one program-memory read port among NUM_CONSUMERS instruction
// fetchers. Requests are granted one at a time in round-robin order. Each
// granted transaction goes through three steps: issue the read, wait for
// memory, then relay the data until the fetcher drops its request.
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous active-high reset
//   consumer_read_valid    per-fetcher request, held until served
//   consumer_read_address  per-fetcher address, slice i = [i*ADDR_BITS +: ADDR_BITS]
//   consumer_read_ready    per-fetcher response strobe (at most one high)
//   consumer_read_data     per-fetcher returned instruction, same slicing
//   mem_read_valid         read request to program memory
//   mem_read_address       address to program memory
//   mem_read_ready         program memory presents data this cycle
//   mem_read_data          program memory read data
//   state_o                current FSM state (debug observation)
//
// Handshake: a fetcher raises consumer_read_valid and holds it until it sees
// its consumer_read_ready bit. Then it drops valid, and ready drops on the
// following edge. On the memory side, mem_read_valid and mem_read_address
// stay stable until mem_read_ready is sampled high. That same edge completes
// the read.
module fetch_arbiter #(
    parameter int NUM_CONSUMERS = 2,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic [1:0]                         state_o
);

    localparam int IDXW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAYING     = 2'd2
    } state_t;

    state_t                    state_q;
    logic [IDXW-1:0]           grant_q;
    logic [IDXW-1:0]           rr_ptr_q;
    logic                      mem_read_valid_q;
    logic [ADDR_BITS-1:0]      mem_read_address_q;
    logic [NUM_CONSUMERS-1:0]  ready_q;
    logic [DATA_BITS-1:0]      data_q [NUM_CONSUMERS];

    logic [ADDR_BITS-1:0]      addr_arr [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0]  valid_arr;

    // Split the flat buses into per-consumer arrays.
    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slice
        assign addr_arr[g]  = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
        assign valid_arr[g] = consumer_read_valid[g];
        assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = data_q[g];
    end

    // Round-robin pick. Rotate the request vector so that rr_ptr lands at
    // bit 0. The lowest set bit of the rotated vector is then the first
    // requester at or above rr_ptr, with wrap-around. The downward loop
    // leaves the smallest offset as the winner.
    logic [2*NUM_CONSUMERS-1:0] req_dbl;
    logic [NUM_CONSUMERS-1:0]   req_rot;
    logic                       pick_found;
    logic [IDXW-1:0]            pick_idx;

    always_comb begin
        req_dbl    = {valid_arr, valid_arr} >> rr_ptr_q;
        req_rot    = req_dbl[NUM_CONSUMERS-1:0];
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'((int'(rr_ptr_q) + k) % NUM_CONSUMERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            grant_q            <= '0;
            rr_ptr_q           <= '0;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            ready_q            <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // mem_read_ready is deliberately ignored here.
                    if (pick_found) begin
                        grant_q            <= pick_idx;
                        mem_read_valid_q   <= 1'b1;
                        mem_read_address_q <= addr_arr[pick_idx];
                        state_q            <= READ_WAITING;
                    end
                end
                READ_WAITING: begin
                    // The read completes even if the request dropped in the
                    // meantime. RELAYING then releases ready one cycle later.
                    if (mem_read_ready) begin
                        mem_read_valid_q  <= 1'b0;
                        data_q[grant_q]   <= mem_read_data;
                        ready_q           <= '0;
                        ready_q[grant_q]  <= 1'b1;
                        state_q           <= RELAYING;
                    end
                end
                RELAYING: begin
                    if (!valid_arr[grant_q]) begin
                        ready_q  <= '0;
                        rr_ptr_q <= IDXW'((int'(grant_q) + 1) % NUM_CONSUMERS);
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign consumer_read_ready = ready_q;
    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;
    assign state_o             = state_q;

endmodule
